// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state encoding and channel constants for the TDM demux
package tdm_pkg;
  localparam int NCH = 4;
  localparam int CNT_W = 2;
  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: time-division 1-to-4 demultiplexer with hunt/locked frame alignment
module tdm_demux_1x4
  import tdm_pkg::*;
#(
  parameter int W = 8,
  parameter int MAX_ERR = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           frame_sync,
  output logic [W-1:0]   y0,
  output logic [W-1:0]   y1,
  output logic [W-1:0]   y2,
  output logic [W-1:0]   y3,
  output logic [NCH-1:0] ch_strobe,
  output logic           frame_done,
  output logic           sync_err,
  output logic           locked
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, wr_ch;
  logic [2:0] ecnt_q, ecnt_d, ecnt_inc;
  logic [NCH-1:0] strobe_q, strobe_d;
  logic fd_q, fd_d, se_q, se_d, lk_q;
  logic acc, early, drop;
  logic [W-1:0] y_q [NCH];
  // In HUNT only a sync beat is accepted; when locked every valid beat lands somewhere.
  // An early sync always restarts the frame at channel 0.
  always_comb begin
    acc = din_valid && (state_q == LOCKED || frame_sync);
    early = din_valid && state_q == LOCKED && frame_sync && cnt_q != '0;
    ecnt_inc = ecnt_q + 3'd1;
    drop = early && ecnt_inc == 3'(MAX_ERR);
    wr_ch = frame_sync ? '0 : cnt_q;
    cnt_d = acc ? wr_ch + 2'd1 : cnt_q;
    fd_d = acc && wr_ch == 2'd3;
    se_d = early;
    strobe_d = acc ? 4'b0001 << wr_ch : '0;
    state_d = drop ? HUNT : (state_q == HUNT && din_valid && frame_sync) ? LOCKED : state_q;
    ecnt_d = (drop || fd_d || (state_q == HUNT && acc)) ? '0 : early ? ecnt_inc : ecnt_q;
  end
  // FSM, counters and single-cycle pulses; locked tracks the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      cnt_q <= '0;
      ecnt_q <= '0;
      strobe_q <= '0;
      fd_q <= 1'b0;
      se_q <= 1'b0;
      lk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ecnt_q <= ecnt_d;
      strobe_q <= strobe_d;
      fd_q <= fd_d;
      se_q <= se_d;
      lk_q <= state_d == LOCKED;
    end
  end
  // Channel registers: only the addressed channel is written, the rest hold stale data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) y_q[k] <= '0;
    end else if (acc) begin
      y_q[wr_ch] <= din;
    end
  end
  assign y0 = y_q[0];
  assign y1 = y_q[1];
  assign y2 = y_q[2];
  assign y3 = y_q[3];
  assign ch_strobe = strobe_q;
  assign frame_done = fd_q;
  assign sync_err = se_q;
  assign locked = lk_q;
endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Receive-side counterpart to the 4-to-1 mux: a time-division 1-to-4 demultiplexer.
- Accepts a serial stream of W-bit samples, one channel per valid beat, with channel 0 marked by frame_sync.
- Steers each sample into one of four registered channel outputs, with per-channel update strobes.
- Tracks frame alignment with a hunt/locked FSM; sits between a serial link and per-channel consumers.

Parameters:
- W, 8, sample width in bits.
- MAX_ERR, 2, consecutive sync errors that drop the block from LOCKED back to HUNT (range 1..7).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  W  serial sample.
- din_valid  input  1  din holds a sample this cycle.
- frame_sync  input  1  qualifies the current valid sample as channel 0; ignored when din_valid=0.
- y0, y1, y2, y3  output  W each  registered channel outputs; each holds its last written sample.
- ch_strobe  output  4  one-cycle pulse; bit k=1 in the cycle yk takes a new value.
- frame_done  output  1  one-cycle pulse, coincident with ch_strobe[3].
- sync_err  output  1  one-cycle pulse on a misaligned frame_sync.
- locked  output  1  1 while the FSM is in LOCKED.

Behaviour:
- Reset: synchronous, active-high, and dominates all other inputs in that cycle.
  - y0..y3=0, ch_strobe=0, frame_done=0, sync_err=0, locked=0.
  - State=HUNT, channel counter cnt=0, error counter ecnt=0.
- Latency: a sample accepted at edge N appears on yk, with its ch_strobe bit, after edge N. This is one cycle; there is no buffering and no backpressure.
- Cycles with din_valid=0: no writes, all strobes and pulses 0, state held.
- HUNT:
  - valid with sync=0: sample discarded, no strobe.
  - valid with sync=1: y0<=din, ch_strobe=0001, cnt<=1, ecnt<=0, go to LOCKED.
- LOCKED, valid with sync=0:
  - y[cnt]<=din, ch_strobe bit cnt set, cnt<=cnt+1 (2-bit, wraps 3->0).
  - When cnt==3: frame_done=1 and ecnt<=0 (a clean complete frame clears errors).
- LOCKED, valid with sync=1 and cnt==0: normal channel-0 write, no error.
- LOCKED, valid with sync=1 and cnt!=0 (early sync, partial frame):
  - sync_err=1.
  - y0<=din, ch_strobe=0001, cnt<=1 (resync).
  - Channels not written in the partial frame keep stale values.
  - ecnt<=ecnt+1. If ecnt+1==MAX_ERR: go to HUNT, locked<=0, ecnt<=0. The resyncing write to y0 still happens.
- Missing sync (a valid beat at cnt==0 with sync=0) is accepted as channel 0 with no error. Alignment is enforced only by early sync.
- locked is registered from the state: it rises the cycle after the sync beat in HUNT and falls the cycle after the MAX_ERR-th error.
- ch_strobe is one-hot or zero and is never multi-bit.

Decomposition:
- Shared package tdm_pkg:
  - state encoding typedef (HUNT=1'b0, LOCKED=1'b1).
  - NCH=4 and CNT_W=2 constants.
- No sub-module is needed; one always block for the FSM and counters, and one for the channel registers.

Test Plan:
1. Reset, then in HUNT: valid beats 8'hAA, 8'hBB with sync=0 -> no ch_strobe, y0..y3=0, locked=0.
2. Sync beat 8'h11 followed by 8'h22, 8'h33, 8'h44 ->
   - strobes 0001, 0010, 0100, 1000 on successive cycles.
   - frame_done pulses with 1000.
   - final y0..y3 = 11, 22, 33, 44; locked=1 from the cycle after 8'h11.
3. Locked; sync at cnt=2 with din=8'h55 -> sync_err=1, y0=55, y2 and y3 keep old values, next strobe 0010, locked stays 1.
4. MAX_ERR=2: two consecutive early syncs (din=8'h66 then 8'h77), separated by one beat so cnt!=0 -> second error makes locked=0 and y0=77. A following valid with sync=0 is discarded.
5. Valid gaps: sync 8'h01, idle 3 cycles, then 8'h02 -> 8'h02 lands on y1 with strobe 0010; idle cycles show no strobes.
6. rst=1 mid-frame (cnt=2) while din_valid=1 -> all outputs 0 and locked=0 after the edge; the sample is not written.
